// File: rtl/sm4_pkg.sv
// Shared SM4 definitions: S-box table, engine states and the round linear transform.
package sm4_pkg;

    localparam int SM4_MAX_ROUNDS = 32;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } sm4_eng_state_t;

    localparam logic [7:0] SM4_SBOX [256] = '{
        8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
        8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
        8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
        8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
        8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
        8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
        8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
        8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
        8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
        8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
        8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
        8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
        8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
        8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
        8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
        8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
    };

    function automatic logic [31:0] sm4_rotl32(input logic [31:0] x, input logic [4:0] n);
        logic [63:0] d;
        d = {x, x} << n;
        return d[63:32];
    endfunction

    function automatic logic [31:0] sm4_l_enc(input logic [31:0] b);
        return b ^ sm4_rotl32(b, 5'd2) ^ sm4_rotl32(b, 5'd10)
                 ^ sm4_rotl32(b, 5'd18) ^ sm4_rotl32(b, 5'd24);
    endfunction

endpackage

// File: rtl/sm4_round_f.sv
// One combinational SM4 round: shift the word window and fold T(X1^X2^X3^rk) into X0.
module sm4_round_f
    import sm4_pkg::*;
(
    input  logic [127:0] x,
    input  logic [31:0]  rk,
    output logic [127:0] x_next
);

    logic [31:0] a;
    logic [31:0] b;

    always_comb begin
        b = '0;
        a = x[95:64] ^ x[63:32] ^ x[31:0] ^ rk;
        for (int i = 0; i < 4; i++) begin
            b[8*i +: 8] = SM4_SBOX[a[8*i +: 8]];
        end
        x_next = {x[95:0], x[127:96] ^ sm4_l_enc(b)};
    end

endmodule

// File: rtl/sm4_round_engine.sv
// Iterative SM4 round engine, one round per cycle or two when
// SM4_TWO_ROUNDS_PER_CYCLE_EN is defined.
module sm4_round_engine
    import sm4_pkg::*;
#(
    parameter int NUM_ROUNDS = 32
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         sm4_enable_in,
    input  logic                         key_exp_finished_in,
    input  logic [32*SM4_MAX_ROUNDS-1:0] rk_bus_in,
    input  logic [127:0]                 data_in,
    input  logic                         data_valid_in,
    output logic                         data_ready_out,
    output logic [127:0]                 result_out,
    output logic                         result_valid_out,
    input  logic                         result_ready_in,
    output logic                         busy_out
);

`ifdef SM4_TWO_ROUNDS_PER_CYCLE_EN
    localparam int STEP_N = 2;
`else
    localparam int STEP_N = 1;
`endif
    localparam logic [4:0] STEP     = 5'(STEP_N);
    localparam logic [4:0] LAST_CNT = 5'(NUM_ROUNDS - STEP_N);

    sm4_eng_state_t state_q, state_d;
    logic [127:0]   x_q, x_d, x_step, x_r0;
    logic [4:0]     round_cnt, cnt_d;
    logic [9:0]     rk_base;
    logic           accept, abort;

    assign rk_base = {round_cnt, 5'd0};

    sm4_round_f u_round0 (
        .x      (x_q),
        .rk     (rk_bus_in[rk_base +: 32]),
        .x_next (x_r0)
    );

`ifdef SM4_TWO_ROUNDS_PER_CYCLE_EN
    logic [127:0] x_r1;

    sm4_round_f u_round1 (
        .x      (x_r0),
        .rk     (rk_bus_in[rk_base + 10'd32 +: 32]),
        .x_next (x_r1)
    );

    assign x_step = x_r1;
`else
    assign x_step = x_r0;
`endif

    // Gating with reset_n keeps ready low while reset is held.
    assign data_ready_out = reset_n && (state_q == IDLE)
                         && sm4_enable_in && key_exp_finished_in;
    assign accept = data_valid_in && data_ready_out;
    assign abort  = !sm4_enable_in || !key_exp_finished_in;

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        cnt_d   = round_cnt;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = BUSY;
                    x_d     = data_in;
                    cnt_d   = '0;
                end
            end
            BUSY: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    x_d = x_step;
                    if (round_cnt == LAST_CNT) begin
                        state_d = DONE;
                    end else begin
                        cnt_d = round_cnt + STEP;
                    end
                end
            end
            DONE: begin
                if (abort || result_ready_in) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            x_q       <= '0;
            round_cnt <= '0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            round_cnt <= cnt_d;
        end
    end

    assign result_valid_out = (state_q == DONE);
    assign busy_out         = (state_q == BUSY);
    assign result_out       = (state_q == DONE)
                            ? {x_q[31:0], x_q[63:32], x_q[95:64], x_q[127:96]}
                            : '0;

endmodule

// File: tb/tb_sm4_round_engine.sv
// Randomised bench for sm4_round_engine against a word-list SM4 model
// with its own key expansion.
module tb_sm4_round_engine;

    localparam int NR = 32;
`ifdef SM4_TWO_ROUNDS_PER_CYCLE_EN
    localparam int LAT = NR / 2;
`else
    localparam int LAT = NR;
`endif

    localparam logic [127:0] KEY = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] PT  = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] CT  = 128'h681edf34d206965e86b3e94f536e4246;

    logic           clk = 1'b0;
    logic           reset_n = 1'b1;
    logic           sm4_enable_in = 1'b0;
    logic           key_exp_finished_in = 1'b0;
    logic [1023:0]  rk_bus_in = '0;
    logic [127:0]   data_in = '0;
    logic           data_valid_in = 1'b0;
    logic           data_ready_out;
    logic [127:0]   result_out;
    logic           result_valid_out;
    logic           result_ready_in = 1'b0;
    logic           busy_out;

    int checks = 0;
    int failures = 0;

    sm4_round_engine #(.NUM_ROUNDS(NR)) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .sm4_enable_in       (sm4_enable_in),
        .key_exp_finished_in (key_exp_finished_in),
        .rk_bus_in           (rk_bus_in),
        .data_in             (data_in),
        .data_valid_in       (data_valid_in),
        .data_ready_out      (data_ready_out),
        .result_out          (result_out),
        .result_valid_out    (result_valid_out),
        .result_ready_in     (result_ready_in),
        .busy_out            (busy_out)
    );

    always #5 clk = ~clk;

    logic [7:0] sbox [256] = '{
        8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
        8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
        8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
        8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
        8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
        8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
        8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
        8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
        8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
        8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
        8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
        8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
        8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
        8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
        8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
        8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
    };

    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [31:0] tau(input logic [31:0] a);
        return {sbox[a[31:24]], sbox[a[23:16]], sbox[a[15:8]], sbox[a[7:0]]};
    endfunction

    function automatic logic [31:0] t_enc(input logic [31:0] a);
        logic [31:0] b;
        b = tau(a);
        return b ^ rotl(b, 2) ^ rotl(b, 10) ^ rotl(b, 18) ^ rotl(b, 24);
    endfunction

    function automatic logic [31:0] t_key(input logic [31:0] a);
        logic [31:0] b;
        b = tau(a);
        return b ^ rotl(b, 13) ^ rotl(b, 23);
    endfunction

    function automatic logic [1023:0] keyexp(input logic [127:0] mk, input bit dec);
        logic [31:0]   fk [4];
        logic [31:0]   k  [36];
        logic [31:0]   ck;
        logic [1023:0] bus;
        fk[0] = 32'ha3b1bac6; fk[1] = 32'h56aa3350;
        fk[2] = 32'h677d9197; fk[3] = 32'hb27022dc;
        for (int i = 0; i < 4; i++) k[i] = mk[127-32*i -: 32] ^ fk[i];
        for (int i = 0; i < 32; i++) begin
            for (int j = 0; j < 4; j++) ck[31-8*j -: 8] = 8'((4*i + j) * 7);
            k[i+4] = k[i] ^ t_key(k[i+1] ^ k[i+2] ^ k[i+3] ^ ck);
        end
        for (int i = 0; i < 32; i++) bus[32*i +: 32] = dec ? k[35-i] : k[i+4];
        return bus;
    endfunction

    function automatic logic [127:0] crypt(input logic [127:0] din, input logic [1023:0] bus);
        logic [31:0] w [NR+4];
        for (int i = 0; i < 4; i++) w[i] = din[127-32*i -: 32];
        for (int i = 0; i < NR; i++)
            w[i+4] = w[i] ^ t_enc(w[i+1] ^ w[i+2] ^ w[i+3] ^ bus[32*i +: 32]);
        return {w[NR+3], w[NR+2], w[NR+1], w[NR]};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: 0 idle, 1 computing (m_cnt edges left), 2 holding m_res.
    int           m_phase = 0;
    int           m_cnt = 0;
    logic [127:0] m_res = '0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_phase <= 0;
            m_cnt   <= 0;
            m_res   <= '0;
        end else begin
            case (m_phase)
                0: if (data_valid_in && sm4_enable_in && key_exp_finished_in) begin
                    m_phase <= 1;
                    m_cnt   <= LAT;
                    m_res   <= crypt(data_in, rk_bus_in);
                end
                1: if (!sm4_enable_in || !key_exp_finished_in) m_phase <= 0;
                   else if (m_cnt == 1) m_phase <= 2;
                   else m_cnt <= m_cnt - 1;
                default: if (!sm4_enable_in || !key_exp_finished_in || result_ready_in)
                    m_phase <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if ($time > 2) begin
            chk("data_ready", 128'(data_ready_out),
                128'(reset_n && m_phase == 0 && sm4_enable_in && key_exp_finished_in));
            chk("busy", 128'(busy_out), 128'(m_phase == 1));
            chk("result_valid", 128'(result_valid_out), 128'(m_phase == 2));
            chk("result", result_out, (m_phase == 2) ? m_res : 128'd0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [127:0] d);
        bit ok;
        ok = 0;
        data_in = d;
        data_valid_in = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (data_ready_out) begin
                ok = 1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL accept_timeout actual=no_accept expected=accept");
        end
        step();
        data_valid_in = 1'b0;
    endtask

    task automatic wait_result(output int lat);
        bit ok;
        ok = 0;
        lat = 0;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            if (result_valid_out) begin
                ok = 1;
                lat = n - 1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL result_timeout actual=no_valid expected=valid");
        end
    endtask

    int           lat;
    logic [1023:0] enc_bus, dec_bus;
    logic [127:0] held;

    initial begin
        enc_bus = keyexp(KEY, 1'b0);
        dec_bus = keyexp(KEY, 1'b1);
        chk("model_rk00", 128'(enc_bus[31:0]), 128'h f12186f9);
        chk("model_rk31", 128'(enc_bus[1023:992]), 128'h9124a012);
        chk("model_enc", crypt(PT, enc_bus), CT);
        chk("model_dec", crypt(CT, dec_bus), PT);

        #1 reset_n = 1'b0;
        sm4_enable_in = 1'b1;
        key_exp_finished_in = 1'b1;
        repeat (3) step();
        reset_n = 1'b1;
        step();

        // Standard vector with backpressure.
        rk_bus_in = enc_bus;
        send(PT);
        wait_result(lat);
        chk("latency_enc", 128'(lat), 128'(LAT));
        chk("std_result", result_out, CT);
        held = result_out;
        repeat (10) step();
        @(negedge clk);
        chk("bp_hold", result_out, held);
        chk("bp_ready_low", 128'(data_ready_out), 128'd0);
        step();

        // Decrypt queued behind the pending result.
        rk_bus_in = dec_bus;
        result_ready_in = 1'b1;
        send(CT);
        result_ready_in = 1'b0;
        wait_result(lat);
        chk("dec_result", result_out, PT);
        step();
        result_ready_in = 1'b1;
        step();
        result_ready_in = 1'b0;

        // Gating on key readiness.
        key_exp_finished_in = 1'b0;
        data_in = {$urandom, $urandom, $urandom, $urandom};
        data_valid_in = 1'b1;
        repeat (5) step();
        @(negedge clk);
        chk("gate_ready", 128'(data_ready_out), 128'd0);
        chk("gate_busy", 128'(busy_out), 128'd0);
        step();
        data_valid_in = 1'b0;
        key_exp_finished_in = 1'b1;
        rk_bus_in = enc_bus;
        step();

        // Abort mid-block.
        send(PT);
        repeat (LAT / 2 + 1) step();
        sm4_enable_in = 1'b0;
        step();
        sm4_enable_in = 1'b1;
        repeat (LAT + 5) step();

        // Abort against result_ready_in in DONE.
        send(PT);
        wait_result(lat);
        step();
        sm4_enable_in = 1'b0;
        result_ready_in = 1'b1;
        step();
        sm4_enable_in = 1'b1;
        result_ready_in = 1'b0;
        step();

        // Asynchronous reset mid-block.
        send(PT);
        repeat (5) step();
        #2 reset_n = 1'b0;
        #1;
        chk("rst_busy", 128'(busy_out), 128'd0);
        chk("rst_ready", 128'(data_ready_out), 128'd0);
        chk("rst_valid", 128'(result_valid_out), 128'd0);
        chk("rst_result", result_out, 128'd0);
        step();
        reset_n = 1'b1;
        step();
        send(PT);
        wait_result(lat);
        chk("post_rst_latency", 128'(lat), 128'(LAT));
        chk("post_rst_result", result_out, CT);
        step();
        result_ready_in = 1'b1;
        step();
        result_ready_in = 1'b0;

        // Random keys, data, backpressure and aborts.
        for (int t = 0; t < 40; t++) begin
            rk_bus_in = keyexp({$urandom, $urandom, $urandom, $urandom}, 1'($urandom));
            sm4_enable_in = 1'b1;
            key_exp_finished_in = 1'b1;
            send({$urandom, $urandom, $urandom, $urandom});
            for (int c = 0; c < 300; c++) begin
                result_ready_in = ($urandom_range(0, 2) != 0);
                sm4_enable_in = ($urandom_range(0, 99) != 0);
                key_exp_finished_in = ($urandom_range(0, 149) != 0);
                step();
                if (m_phase == 0) break;
            end
            sm4_enable_in = 1'b1;
            key_exp_finished_in = 1'b1;
            result_ready_in = 1'b0;
            step();
        end

        repeat (3) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
